// File: rtl/iic_slave.sv
`default_nettype none
// ============================================================================
// Module   : iic_slave
// Purpose  : I2C slave with a fixed 7-bit device address and a byte-wide
//            register port. SCL/SDA are oversampled on CLOCK; SDA is
//            open-drain (pulled low or released, never driven high).
// Options  : IIC_SLAVE_AUTOINC_EN - oAddr auto-increments across burst bytes.
// Revision : 1.0 - initial release
// ============================================================================
module iic_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010_001,
  parameter logic [9:0] THOLD      = 10'd10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       oWrite,
  output logic       oRead,
  output logic [7:0] oAddr,
  output logic [7:0] oData,
  input  logic [7:0] iData,
  output logic       oBusy
);

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEVADDR   = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_WORDADDR  = 4'd3;
  localparam logic [3:0] S_WADDR_ACK = 4'd4;
  localparam logic [3:0] S_WRDATA    = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDDATA    = 4'd7;
  localparam logic [3:0] S_MACK      = 4'd8;
  localparam logic [3:0] S_IGNORE    = 4'd9;
  localparam logic [3:0] S_WAIT      = 4'd10;

  // [0] first sync stage, [1] synchronised value, [2] history
  logic [2:0] scl_q, sda_q;
  logic [3:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic       load_q, load_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;

  logic       sda_s, scl_rise, scl_fall, bus_start, bus_stop;
  logic       hold_tick, last_bit, byte_done, addr_match;
  logic [7:0] byte_in;

  assign sda_s      = sda_q[1];
  assign scl_rise   =  scl_q[1] & ~scl_q[2];
  assign scl_fall   = ~scl_q[1] &  scl_q[2];
  assign bus_start  =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign bus_stop   =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
  assign hold_tick  = (hold_cnt_q == 10'd1);
  assign byte_in    = {shift_q[6:0], sda_s};
  assign last_bit   = scl_rise && (bit_cnt_q == 4'd7);
  assign byte_done  = scl_fall && (bit_cnt_q == 4'd8);
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

  // Open-drain bus driver: a reset clears sda_oe_q asynchronously
  assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
  assign oWrite = write_q;
  assign oRead  = read_q;
  assign oAddr  = addr_q;
  assign oData  = data_q;
  assign oBusy  = busy_q;

  // Bus input synchronisers; reset to the idle (high) level to avoid false edges
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], SCL};
      sda_q <= {sda_q[1:0], SDA};
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: START/STOP override everything, byte/ACK steps advance on SCL fall
  always_comb begin
    state_d = state_q;
    if (bus_start) begin
      state_d = S_DEVADDR;
    end else if (bus_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DEVADDR:   if (byte_done) state_d = addr_match ? S_DEV_ACK : S_IGNORE;
        S_DEV_ACK:   if (scl_fall)  state_d = rw_q ? S_RDDATA : S_WORDADDR;
        S_WORDADDR:  if (byte_done) state_d = S_WADDR_ACK;
        S_WADDR_ACK: if (scl_fall)  state_d = S_WRDATA;
        S_WRDATA:    if (byte_done) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall)  state_d = S_WRDATA;
        S_RDDATA:    if (byte_done) state_d = S_MACK;
        S_MACK:      if (scl_fall)  state_d = mack_q ? S_WAIT : S_RDDATA;
        default:     ;
      endcase
    end
  end

  // Datapath and outputs: shifting, SDA scheduling, register-port strobes
  always_comb begin
    shift_d    = shift_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sda_oe_d   = sda_oe_q;
    write_d    = 1'b0;
    read_d     = 1'b0;
    load_d     = read_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    mack_d     = mack_q;

    // Hold timer restarts on every SCL fall; SDA changes only when it expires
    if (hold_cnt_q != 10'd0) hold_cnt_d = hold_cnt_q - 10'd1;
    if (scl_fall)            hold_cnt_d = THOLD;

    if (hold_tick) begin
      case (state_q)
        S_DEV_ACK, S_WADDR_ACK, S_WDATA_ACK: sda_oe_d = 1'b1;
        S_RDDATA:                            sda_oe_d = ~tx_q[7];
        default:                             sda_oe_d = 1'b0;
      endcase
    end

    // Read byte is captured the cycle after the oRead strobe
    if (load_q) tx_d = iData;
    // Pointer moves only after the write strobe has been seen with the old value
    if (AUTOINC && write_q) addr_d = addr_q + 8'd1;

    if (scl_rise) begin
      case (state_q)
        S_DEVADDR, S_WORDADDR, S_WRDATA: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        S_RDDATA: begin
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        S_MACK: begin
          mack_d = sda_s;
          if (AUTOINC && !sda_s) addr_d = addr_q + 8'd1;
        end
        default: ;
      endcase
      if (state_q == S_WORDADDR && last_bit) addr_d = byte_in;
      if (state_q == S_WRDATA && last_bit) begin
        write_d = 1'b1;
        data_d  = byte_in;
      end
    end

    if (state_d != state_q) bit_cnt_d = 4'd0;
    if (state_q != S_RDDATA && state_d == S_RDDATA) read_d = 1'b1;
    if (state_q == S_DEVADDR && state_d == S_DEV_ACK) begin
      busy_d = 1'b1;
      rw_d   = shift_q[0];
    end

    // Bus conditions abandon any partial byte and free the line at once
    if (bus_start || bus_stop) begin
      bit_cnt_d  = 4'd0;
      hold_cnt_d = 10'd0;
      sda_oe_d   = 1'b0;
    end
    if (bus_stop) busy_d = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      bit_cnt_q  <= 4'd0;
      hold_cnt_q <= 10'd0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      sda_oe_q   <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sda_oe_q   <= sda_oe_d;
      write_q    <= write_d;
      read_q     <= read_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iic_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_slave
// Purpose  : Self-checking bench for iic_slave: a bit-level I2C master model,
//            a table of write frames and hand-written read/abort/reset cases.
//            Expected register-port writes and reads are queued when a frame
//            is launched and popped when the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_slave;

  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       owrite, oread, obusy;
  logic [7:0] oaddr, odata, idata;

  int total = 0;
  int bad   = 0;
  int sda_low_cnt = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        wexp[$];
  logic [7:0] rexp[$];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       ack;
  } vec_t;
  vec_t vecs[6];

  always #10 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  // Register file stand-in: read data is a fixed function of the pointer
  assign idata = oaddr ^ 8'h5F;

  iic_slave dut (
    .CLOCK  (clk),
    .RESET  (rst_n),
    .SCL    (scl),
    .SDA    (sda),
    .oWrite (owrite),
    .oRead  (oread),
    .oAddr  (oaddr),
    .oData  (odata),
    .iData  (idata),
    .oBusy  (obusy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles where the line is low while the master has released it
  always @(posedge clk) if (!m_low && sda === 1'b0) sda_low_cnt++;

  // Scoreboard: write strobes
  always @(negedge clk) begin
    if (rst_n && owrite) begin
      check("write_expected", wexp.size() != 0, 1'b1);
      if (wexp.size() != 0) begin
        wr_t e;
        e = wexp.pop_front();
        check("write_addr", oaddr, e.a);
        check("write_data", odata, e.d);
      end
    end
  end

  // Scoreboard: read requests
  always @(negedge clk) begin
    if (rst_n && oread) begin
      check("read_expected", rexp.size() != 0, 1'b1);
      if (rexp.size() != 0) begin
        logic [7:0] ea;
        ea = rexp.pop_front();
        check("read_addr", oaddr, ea);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_bit(input logic b, output logic s);
    wait_cyc(4);
    m_low = ~b;
    wait_cyc(HALF);
    scl = 1'b1;
    wait_cyc(HALF / 2);
    s = sda;
    wait_cyc(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic m_start();
    wait_cyc(4);
    m_low = 1'b0;
    wait_cyc(HALF);
    scl = 1'b1;
    wait_cyc(HALF);
    m_low = 1'b1;
    wait_cyc(HALF);
    scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_cyc(4);
    m_low = 1'b1;
    wait_cyc(HALF);
    scl = 1'b1;
    wait_cyc(HALF);
    m_low = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic m_wbyte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(v[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_rbyte(input logic mack, output logic [7:0] d, output logic s);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, b);
      d[i] = b;
    end
    m_bit(~mack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    int         low0;

    vecs[0] = '{dev: 8'hA2, waddr: 8'h05, wdata: 8'h3C, ack: 1'b1};
    vecs[1] = '{dev: 8'hA4, waddr: 8'h05, wdata: 8'h00, ack: 1'b0};
    vecs[2] = '{dev: 8'hA2, waddr: 8'h80, wdata: 8'hC3, ack: 1'b1};
    vecs[3] = '{dev: 8'hA0, waddr: 8'h10, wdata: 8'h55, ack: 1'b0};
    vecs[4] = '{dev: 8'h22, waddr: 8'h33, wdata: 8'h44, ack: 1'b0};
    vecs[5] = '{dev: 8'hA2, waddr: 8'hFE, wdata: 8'h01, ack: 1'b1};

    rst_n = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    wait_cyc(5);
    check("rst_owrite", owrite, 1'b0);
    check("rst_oread",  oread,  1'b0);
    check("rst_oaddr",  oaddr,  8'h00);
    check("rst_odata",  odata,  8'h00);
    check("rst_obusy",  obusy,  1'b0);
    check("rst_sda",    sda,    1'b1);
    rst_n = 1'b1;
    wait_cyc(10);

    // Table-driven single-byte write frames (matched and mismatched addresses)
    for (int i = 0; i < 6; i++) begin
      low0 = sda_low_cnt;
      if (vecs[i].ack) wexp.push_back(wr_t'{a: vecs[i].waddr, d: vecs[i].wdata});
      m_start();
      m_wbyte(vecs[i].dev, ack);
      check("dev_ack", ack, vecs[i].ack);
      m_wbyte(vecs[i].waddr, ack);
      check("waddr_ack", ack, vecs[i].ack);
      if (vecs[i].ack) begin
        m_wbyte(vecs[i].wdata, ack);
        check("data_ack", ack, 1'b1);
      end
      check("busy_in_frame", obusy, vecs[i].ack);
      m_stop();
      check("busy_after_stop", obusy, 1'b0);
      if (!vecs[i].ack) check("sda_untouched", sda_low_cnt - low0, 0);
      check("write_queue_drained", wexp.size(), 0);
    end

    // Random read: set pointer, repeated START, read one byte, NACK
    rexp.push_back(8'h05);
    m_start();
    m_wbyte(8'hA2, ack);  check("rr_dev_ack", ack, 1'b1);
    m_wbyte(8'h05, ack);  check("rr_waddr_ack", ack, 1'b1);
    m_start();
    m_wbyte(8'hA3, ack);  check("rr_rdev_ack", ack, 1'b1);
    check("rr_busy", obusy, 1'b1);
    m_rbyte(1'b0, rb, s);
    check("rr_data", rb, 8'h5A);
    check("rr_mack_released", s, 1'b1);
    m_stop();
    check("rr_busy_after_stop", obusy, 1'b0);
    check("rr_read_queue_drained", rexp.size(), 0);

    // Burst read across the pointer wrap
    rexp.push_back(8'hFF);
`ifdef IIC_SLAVE_AUTOINC_EN
    rexp.push_back(8'h00);
`else
    rexp.push_back(8'hFF);
`endif
    m_start();
    m_wbyte(8'hA2, ack);  check("br_dev_ack", ack, 1'b1);
    m_wbyte(8'hFF, ack);  check("br_waddr_ack", ack, 1'b1);
    m_start();
    m_wbyte(8'hA3, ack);  check("br_rdev_ack", ack, 1'b1);
    m_rbyte(1'b1, rb, s);
    check("br_data0", rb, 8'hA0);
    m_rbyte(1'b0, rb, s);
`ifdef IIC_SLAVE_AUTOINC_EN
    check("br_data1", rb, 8'h5F);
`else
    check("br_data1", rb, 8'hA0);
`endif
    check("br_mack_released", s, 1'b1);
    m_stop();
    check("br_read_queue_drained", rexp.size(), 0);

    // Burst write starting at 0xFF
    wexp.push_back(wr_t'{a: 8'hFF, d: 8'h11});
`ifdef IIC_SLAVE_AUTOINC_EN
    wexp.push_back(wr_t'{a: 8'h00, d: 8'h22});
`else
    wexp.push_back(wr_t'{a: 8'hFF, d: 8'h22});
`endif
    m_start();
    m_wbyte(8'hA2, ack);  check("bw_dev_ack", ack, 1'b1);
    m_wbyte(8'hFF, ack);  check("bw_waddr_ack", ack, 1'b1);
    m_wbyte(8'h11, ack);  check("bw_data0_ack", ack, 1'b1);
    m_wbyte(8'h22, ack);  check("bw_data1_ack", ack, 1'b1);
    m_stop();
    check("bw_write_queue_drained", wexp.size(), 0);

    // STOP after four data bits: no write, then a normal frame
    m_start();
    m_wbyte(8'hA2, ack);  check("sm_dev_ack", ack, 1'b1);
    m_wbyte(8'h10, ack);  check("sm_waddr_ack", ack, 1'b1);
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
    m_stop();
    check("sm_busy_after_stop", obusy, 1'b0);
    wexp.push_back(wr_t'{a: 8'h10, d: 8'h77});
    m_start();
    m_wbyte(8'hA2, ack);  check("sm2_dev_ack", ack, 1'b1);
    m_wbyte(8'h10, ack);  check("sm2_waddr_ack", ack, 1'b1);
    m_wbyte(8'h77, ack);  check("sm2_data_ack", ack, 1'b1);
    m_stop();
    check("sm_write_queue_drained", wexp.size(), 0);

    // Reset while the slave holds the address ACK low
    m_start();
    for (int i = 7; i >= 0; i--) begin
      rb = 8'hA2;
      m_bit(rb[i], s);
    end
    m_low = 1'b0;
    wait_cyc(20);
    check("ra_ack_driven", sda, 1'b0);
    check("ra_busy_before", obusy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ra_sda_released", sda, 1'b1);
    check("ra_owrite", owrite, 1'b0);
    check("ra_oread",  oread,  1'b0);
    check("ra_oaddr",  oaddr,  8'h00);
    check("ra_odata",  odata,  8'h00);
    check("ra_obusy",  obusy,  1'b0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    wexp.push_back(wr_t'{a: 8'h33, d: 8'h44});
    m_start();
    m_wbyte(8'hA2, ack);  check("ra2_dev_ack", ack, 1'b1);
    m_wbyte(8'h33, ack);  check("ra2_waddr_ack", ack, 1'b1);
    m_wbyte(8'h44, ack);  check("ra2_data_ack", ack, 1'b1);
    m_stop();
    check("ra2_write_queue_drained", wexp.size(), 0);
    check("final_read_queue_drained", rexp.size(), 0);

    wait_cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
